memory_be: RTL
==============

# memory_be

Single-port synchronous RAM with a valid/ready request interface, per-lane write enables, a configurable read pipeline, and a hardware clear sequencer. It is the parametrised successor to the plain `Memory` block. It replaces the bidirectional data bus with separate write and read paths. Bus masters and DMA engines use it as their local scratch store.

## Interface
Parameters:
- ADDR_WIDTH, 5: address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 16: word width; must be an integer multiple of LANE_WIDTH.
- LANE_WIDTH, 8: width of one write-enable lane; LANES = DATA_WIDTH/LANE_WIDTH.
- READ_LATENCY, 2: cycles from read accept to rsp_valid; legal range 1..4.
- CLEAR_ON_RESET, 1: 1 zero-fills the array after reset; 0 skips the fill.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_lane_en  in  LANES  per-lane write enable; ignored on reads.
- clr  in  1  single-cycle pulse that starts a clear sequence.
- busy  out  1  clear sequence in progress.
- rsp_valid  out  1  read data valid, asserted for one cycle per accepted read.
- rsp_data  out  DATA_WIDTH  read data.

## Operation
- The block has two states: CLEAR and READY. req_ready = (state == READY) && !rst. busy = (state == CLEAR).
- Reset:
  - rsp_valid = 0, rsp_data = 0, and the read pipeline is flushed.
  - The clear counter is set to 0.
  - The next state is CLEAR if CLEAR_ON_RESET = 1, otherwise READY.
  - The array contents are not touched by rst itself.
- CLEAR:
  - One word per cycle, in ascending order, is written to 0 at address = counter. The counter then increments.
  - After the edge that writes DEPTH-1, the state moves to READY.
  - clr is ignored in this state. Requests are not accepted.
- READY, request accept:
  - A request is accepted on an edge where req_valid && req_ready.
  - Write: for each lane i with req_lane_en[i] = 1, mem[addr][i*LANE_WIDTH +: LANE_WIDTH] takes the corresponding req_wdata lane. Other lanes keep their value. A write with req_lane_en = 0 is accepted as a no-op. Writes produce no response.
  - Read: the word at req_addr is sampled at the accept edge and travels down a READY_LATENCY-stage valid/data pipeline. Reads are fully pipelined at one per cycle. No backpressure exists on the response side.
- clr pulse in READY:
  - The state moves to CLEAR with the counter at 0.
  - A request presented in the same cycle is still accepted.
  - Reads already in flight complete normally with their sampled data.
- Read-after-write: a read accepted on the cycle after a write to the same address returns the new data.
- rst asserted mid-operation: in-flight reads are dropped (rsp_valid = 0 from the next edge), then the reset sequence applies.

## Timing
- Read latency: a read accepted at edge N gives rsp_valid = 1 and valid rsp_data after edge N + READ_LATENCY.
- rsp_data holds its last value while rsp_valid = 0.
- CLEAR duration: exactly DEPTH cycles. req_ready rises after edge DEPTH, counted from the first edge with rst = 0 or from the clr edge.
- CLEAR_ON_RESET = 0: req_ready = 1 in the first cycle after rst deasserts.
- Throughput: one request per cycle in READY. Zero accepts occur during CLEAR.

## Configuration
- MEMORY_PARITY_EN defined:
  - Each lane stores one extra even-parity bit, computed at write and during CLEAR (parity of 0 = 0).
  - Added ports: req_par_flip (in, 1) inverts the stored parity bits of the enabled lanes for that write, for error injection. rsp_par_err (out, LANES) flags a parity mismatch per lane, aligned with rsp_valid, and resets to 0.
- MEMORY_PARITY_EN undefined: no parity storage; req_par_flip and rsp_par_err do not exist.

## Test plan
All scenarios use ADDR_WIDTH = 5, DATA_WIDTH = 16, LANE_WIDTH = 8, READ_LATENCY = 2.
- Reset clear: release rst with CLEAR_ON_RESET = 1 -> busy = 1 and req_ready = 0 for 32 cycles, then req_ready = 1. Reads of addresses 0, 31 and 21 return 0x0000.
- Full write/read: write 0xF00F to address 0 and 0x0FF0 to address 31 with lanes 2'b11, then read both -> rsp_valid exactly 2 cycles after each accept, returning 0xF00F and 0x0FF0.
- Lane merge: write 0xAAAA to address 21 with lanes 11, then 0x5555 with lanes 01 -> a read returns 0xAA55.
- Back-to-back pipeline: with addr 10 = 0x1234 and addr 11 = 0x5678, read 10, 11, 10 on consecutive cycles -> three consecutive rsp_valid pulses carrying 0x1234, 0x5678, 0x1234.
- clr with in-flight read: read address 10 (value 0x1234) and pulse clr on the same cycle -> the response is 0x1234, busy = 1 for 32 cycles, and address 10 reads 0x0000 afterwards.
- Parity (macro on): write 0x00FF to address 3 with req_par_flip = 1 and lanes 01 -> a read gives rsp_par_err = 2'b01.

Source files
------------

// File: rtl/memory_be.sv
`default_nettype none
// ============================================================================
//  Module   : memory_be
//  Purpose  : Single-port synchronous scratch RAM with a valid/ready request
//             port, per-lane write enables, a READ_LATENCY-deep read
//             pipeline and a hardware zero-fill sequencer (CLEAR state).
//  Options  : define MEMORY_PARITY_EN to store one even-parity bit per lane,
//             add the req_par_flip error-injection input and the per-lane
//             rsp_par_err output.
//  Revision : 1.0  initial release
// ============================================================================
module memory_be #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 16,
    parameter int LANE_WIDTH     = 8,
    parameter int READ_LATENCY   = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_wr,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] req_lane_en,
`ifdef MEMORY_PARITY_EN
    input  logic                             req_par_flip,
    output logic [DATA_WIDTH/LANE_WIDTH-1:0] rsp_par_err,
`endif
    input  logic                             clr,
    output logic                             busy,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data
);

    localparam int c_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    // Elaboration-time sanity checks on the parameter set
    if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_chk_lanes
        $error("memory_be: DATA_WIDTH must be a multiple of LANE_WIDTH");
    end
    if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_chk_latency
        $error("memory_be: READ_LATENCY must be in 1..4");
    end

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam state_e c_RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    // ------------------------------------------------------------------------
    // State, storage and pipeline registers
    // ------------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0]   mem_q [c_DEPTH];

    logic [READ_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
    logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_data_d [READ_LATENCY];

    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

    // ------------------------------------------------------------------------
    // Combinational request decode and array write port
    // ------------------------------------------------------------------------
    logic                    w_accept;
    logic                    w_wr_accept;
    logic                    w_rd_accept;
    logic                    w_clearing;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;
    logic [c_LANES-1:0]      w_mem_lane_we;
    logic [DATA_WIDTH-1:0]   w_rd_data;

`ifdef MEMORY_PARITY_EN
    logic [c_LANES-1:0]      par_mem_q [c_DEPTH];
    logic [c_LANES-1:0]      pipe_par_q [READ_LATENCY];
    logic [c_LANES-1:0]      pipe_par_d [READ_LATENCY];
    logic [c_LANES-1:0]      rsp_par_err_q, rsp_par_err_d;
    logic [c_LANES-1:0]      w_mem_wpar;
    logic [c_LANES-1:0]      w_rd_par;
    logic [c_LANES-1:0]      w_par_mism;
`endif

    // A request can only be taken in READY and never while reset is held
    assign req_ready   = (state_q == ST_READY) && !rst;
    assign busy        = (state_q == ST_CLEAR);
    assign w_accept    = req_valid && req_ready;
    assign w_wr_accept = w_accept && req_wr;
    assign w_rd_accept = w_accept && !req_wr;
    // Reset must not disturb the array, so the fill only runs once rst drops
    assign w_clearing  = (state_q == ST_CLEAR) && !rst;
    assign w_rd_data   = mem_q[req_addr];

    // Select between the clear sequencer and the request port for the single write port
    always_comb begin
        w_mem_addr    = req_addr;
        w_mem_wdata   = req_wdata;
        w_mem_lane_we = '0;
        if (w_clearing) begin
            w_mem_addr    = cnt_q;
            w_mem_wdata   = '0;
            w_mem_lane_we = '1;
        end else if (w_wr_accept) begin
            w_mem_lane_we = req_lane_en;
        end
    end

`ifdef MEMORY_PARITY_EN
    assign w_rd_par = par_mem_q[req_addr];

    // Even parity per written lane; injection only applies to real writes, never the fill
    always_comb begin
        w_mem_wpar = '0;
        for (int i = 0; i < c_LANES; i++) begin
            w_mem_wpar[i] = (^w_mem_wdata[i*LANE_WIDTH +: LANE_WIDTH])
                          ^ (req_par_flip & ~w_clearing);
        end
    end
`endif

    // Lane-masked array write; storage has no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < c_LANES; i++) begin
            if (w_mem_lane_we[i]) begin
                mem_q[w_mem_addr][i*LANE_WIDTH +: LANE_WIDTH] <= w_mem_wdata[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

`ifdef MEMORY_PARITY_EN
    // Lane-masked parity array write, paired with the data array
    always_ff @(posedge clk) begin
        for (int i = 0; i < c_LANES; i++) begin
            if (w_mem_lane_we[i]) begin
                par_mem_q[w_mem_addr][i] <= w_mem_wpar[i];
            end
        end
    end
`endif

    // ------------------------------------------------------------------------
    // CLEAR / READY sequencing
    // ------------------------------------------------------------------------
    // Next-state and clear-counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (&cnt_q) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                // A request in the same cycle as clr has already been accepted
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = c_RESET_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and clear-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------------
    // Stage 0 captures the word at the accept edge; later stages shift it down
    always_comb begin
        pipe_valid_d = '0;
        for (int k = 0; k < READ_LATENCY; k++) begin
            pipe_data_d[k] = '0;
        end
        pipe_valid_d[0] = w_rd_accept;
        pipe_data_d[0]  = w_rd_data;
        for (int k = 1; k < READ_LATENCY; k++) begin
            pipe_valid_d[k] = pipe_valid_q[k-1];
            pipe_data_d[k]  = pipe_data_q[k-1];
        end
        rsp_valid_d = pipe_valid_q[READ_LATENCY-1];
        // rsp_data only moves on a valid response and holds otherwise
        rsp_data_d  = pipe_valid_q[READ_LATENCY-1] ? pipe_data_q[READ_LATENCY-1] : rsp_data_q;
    end

    // Pipeline and response registers; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_data_q[k] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            pipe_valid_q <= pipe_valid_d;
            pipe_data_q  <= pipe_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

`ifdef MEMORY_PARITY_EN
    // Parity bits follow their data word down the pipeline; mismatch is flagged on the output stage
    always_comb begin
        for (int k = 0; k < READ_LATENCY; k++) begin
            pipe_par_d[k] = '0;
        end
        pipe_par_d[0] = w_rd_par;
        for (int k = 1; k < READ_LATENCY; k++) begin
            pipe_par_d[k] = pipe_par_q[k-1];
        end
        w_par_mism = '0;
        for (int i = 0; i < c_LANES; i++) begin
            w_par_mism[i] = (^pipe_data_q[READ_LATENCY-1][i*LANE_WIDTH +: LANE_WIDTH])
                          ^ pipe_par_q[READ_LATENCY-1][i];
        end
        rsp_par_err_d = pipe_valid_q[READ_LATENCY-1] ? w_par_mism : '0;
    end

    // Parity pipeline and error flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_par_q[k] <= '0;
            end
            rsp_par_err_q <= '0;
        end else begin
            pipe_par_q    <= pipe_par_d;
            rsp_par_err_q <= rsp_par_err_d;
        end
    end

    assign rsp_par_err = rsp_par_err_q;
`endif

endmodule
`default_nettype wire
